// File: rtl/tb4004_pkg.sv
// Shared constants and instruction-class type for the 4004-style cycle sequencer.
package tb4004_pkg;

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  localparam logic [3:0] OPR_NOP = 4'h0;
  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_FIN = 4'h3;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_INC = 4'h6;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_ADD = 4'h8;
  localparam logic [3:0] OPR_SUB = 4'h9;
  localparam logic [3:0] OPR_LD  = 4'hA;
  localparam logic [3:0] OPR_XCH = 4'hB;
  localparam logic [3:0] OPR_BBL = 4'hC;
  localparam logic [3:0] OPR_LDM = 4'hD;
  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPR_ACC = 4'hF;

  localparam logic [3:0] OPA_SBM = 4'h8;
  localparam logic [3:0] OPA_ADM = 4'hB;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_TEMP_ACC = 2'd1,
    CLS_ACC      = 2'd2,
    CLS_TWO_WORD = 2'd3
  } instr_cls_e;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: which strobes an instruction needs and whether it is two-word.
module instr_class_decode
  import tb4004_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  output logic       isTwoWord,
  output logic       needTemp,
  output logic       needAcc
);

  instr_cls_e cls;

  always_comb begin
    cls = CLS_NONE;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: cls = CLS_TWO_WORD;
      // opa[0]=1 selects SRC / JIN, which are single-word
      OPR_FIM, OPR_FIN: cls = opa[0] ? CLS_NONE : CLS_TWO_WORD;
      OPR_ADD, OPR_SUB, OPR_LD, OPR_XCH: cls = CLS_TEMP_ACC;
      OPR_BBL, OPR_LDM: cls = CLS_ACC;
      OPR_IO: begin
        if (opa == OPA_SBM || opa == OPA_ADM) cls = CLS_TEMP_ACC;
        else if (opa[3])                      cls = CLS_ACC;
        else                                  cls = CLS_NONE;
      end
      OPR_ACC: begin
        case (opa)
          4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
          4'h8, 4'h9, 4'hB, 4'hC: cls = CLS_ACC;
          default:                cls = CLS_NONE;
        endcase
      end
      default: cls = CLS_NONE;
    endcase
  end

  assign isTwoWord = (cls == CLS_TWO_WORD);
  assign needTemp  = (cls == CLS_TEMP_ACC);
  assign needAcc   = (cls == CLS_TEMP_ACC) || (cls == CLS_ACC);

endmodule

// File: rtl/cycle_sequencer.sv
// 4004-style machine-cycle sequencer: phase counter, run/hold control, OPR/OPA latches, write strobes.
// Optional SEQ_SINGLE_STEP_EN adds stepReq to release one machine cycle at a time from A1.
module cycle_sequencer
  import tb4004_pkg::*;
#(
  parameter int TEMP_WE_PHASE = 5,
  parameter int ACC_WE_PHASE  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       runEn,
  input  logic [3:0] dataIn,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       stepReq,
`endif
  output logic [2:0] phase,
  output logic       sync,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic       secondCycle,
  output logic       pcInc,
  output logic       tempWe,
  output logic       accWe
);

  logic [2:0] phase_q, phase_d;
  logic       hold_q, hold_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic       second_q, second_d;
  logic       sync_q, sync_d;
  logic       pc_inc_q, pc_inc_d;
  logic       temp_we_q, temp_we_d;
  logic       acc_we_q, acc_we_d;

  logic       release_req;
  logic       stop_at_x3;
  logic       two_word;
  logic       need_temp;
  logic       need_acc;

`ifdef SEQ_SINGLE_STEP_EN
  // step_q marks a cycle released by stepReq, which must park again at its X3
  logic step_q, step_d;

  assign release_req = runEn | stepReq;
  assign stop_at_x3  = ~runEn | step_q;

  always_comb begin
    step_d = step_q;
    if (hold_q && release_req) step_d = stepReq;
    else if (phase_q == PH_X3) step_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step_d;
  end
`else
  assign release_req = runEn;
  assign stop_at_x3  = ~runEn;
`endif

  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    if (hold_q) begin
      // A1 of the parked cycle is already spent, so release goes straight to A2
      if (release_req) begin
        phase_d = PH_A2;
        hold_d  = 1'b0;
      end
    end else if (phase_q == PH_X3) begin
      phase_d = PH_A1;
      hold_d  = stop_at_x3;
    end else begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_comb begin
    opr_d = opr_q;
    opa_d = opa_q;
    if (!second_q && phase_q == PH_M1) opr_d = dataIn;
    if (!second_q && phase_q == PH_M2) opa_d = dataIn;
  end

  instr_class_decode u_decode (
    .opr       (opr_d),
    .opa       (opa_d),
    .isTwoWord (two_word),
    .needTemp  (need_temp),
    .needAcc   (need_acc)
  );

  always_comb begin
    second_d = second_q;
    if (!hold_q && phase_q == PH_X3) second_d = !second_q && two_word;
    temp_we_d = !second_q && !hold_d && need_temp && (phase_d == 3'(TEMP_WE_PHASE));
    acc_we_d  = !second_q && !hold_d && need_acc  && (phase_d == 3'(ACC_WE_PHASE));
    sync_d    = (phase_d == PH_X3);
    pc_inc_d  = !hold_d && (phase_d == PH_M2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_A1;
      hold_q    <= 1'b0;
      opr_q     <= 4'h0;
      opa_q     <= 4'h0;
      second_q  <= 1'b0;
      sync_q    <= 1'b0;
      pc_inc_q  <= 1'b0;
      temp_we_q <= 1'b0;
      acc_we_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      opr_q     <= opr_d;
      opa_q     <= opa_d;
      second_q  <= second_d;
      sync_q    <= sync_d;
      pc_inc_q  <= pc_inc_d;
      temp_we_q <= temp_we_d;
      acc_we_q  <= acc_we_d;
    end
  end

  assign phase       = phase_q;
  assign sync        = sync_q;
  assign opr         = opr_q;
  assign opa         = opa_q;
  assign secondCycle = second_q;
  assign pcInc       = pc_inc_q;
  assign tempWe      = temp_we_q;
  assign accWe       = acc_we_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer: stimulus queues per-clock expectations, monitor checks them.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       runEn;
  logic [3:0] dataIn;
`ifdef SEQ_SINGLE_STEP_EN
  logic       stepReq;
  logic       step_now = 1'b0;
`endif
  logic [2:0] phase;
  logic       sync;
  logic [3:0] opr;
  logic [3:0] opa;
  logic       secondCycle;
  logic       pcInc;
  logic       tempWe;
  logic       accWe;

  always #5 clk = ~clk;

  cycle_sequencer #(.TEMP_WE_PHASE(5), .ACC_WE_PHASE(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .runEn       (runEn),
    .dataIn      (dataIn),
`ifdef SEQ_SINGLE_STEP_EN
    .stepReq     (stepReq),
`endif
    .phase       (phase),
    .sync        (sync),
    .opr         (opr),
    .opa         (opa),
    .secondCycle (secondCycle),
    .pcInc       (pcInc),
    .tempWe      (tempWe),
    .accWe       (accWe)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic       sy;
    logic       pci;
    logic       twe;
    logic       awe;
    logic       sec;
    logic [3:0] opr;
    logic [3:0] opa;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] cur_opr  = 4'h0;
  logic [3:0] cur_opa  = 4'h0;
  logic       step_mode = 1'b0;

  function automatic exp_t mk(input int ph, input logic sy, input logic pci, input logic twe,
                              input logic awe, input logic sec, input logic [3:0] o_r,
                              input logic [3:0] o_a);
    exp_t e;
    e.ph = 3'(ph); e.sy = sy; e.pci = pci; e.twe = twe; e.awe = awe;
    e.sec = sec; e.opr = o_r; e.opa = o_a;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus; e is the state expected right after the next rising edge
  task automatic drive(input logic r, input logic run, input logic [3:0] din, input exp_t e);
    @(negedge clk);
    rst = r; runEn = run; dataIn = din;
`ifdef SEQ_SINGLE_STEP_EN
    stepReq = step_now;
`endif
    q.push_back(e);
  endtask

  task automatic rst_clk();
    drive(1'b1, 1'b1, 4'h7, mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0));
    cur_opr = 4'h0; cur_opa = 4'h0;
  endtask

  // Machine cycle from phase `start`; runEn toggles outside X3 and must be ignored there
  task automatic push_cycle(input int start, input logic [3:0] w1, input logic [3:0] w2,
                            input logic sec, input logic twe, input logic awe,
                            input logic [3:0] eopr, input logic [3:0] eopa);
    for (int p = start; p < 8; p++) begin
      logic run;
      logic [3:0] din;
      run = step_mode ? 1'b0 : ((p <= 1) ? 1'b1 : (p % 2 == 0));
      din = (p == 4) ? w1 : (p == 5) ? w2 : 4'(p + 9);
`ifdef SEQ_SINGLE_STEP_EN
      step_now = step_mode && (p == 1);
`endif
      drive(1'b0, run, din,
            mk(p, p == 7, p == 4, twe && p == 5, awe && p == 6, sec,
               (p >= 4) ? eopr : cur_opr, (p >= 5) ? eopa : cur_opa));
    end
`ifdef SEQ_SINGLE_STEP_EN
    step_now = 1'b0;
`endif
    cur_opr = eopr; cur_opa = eopa;
  endtask

  task automatic stall(input int n, input logic sec);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 4'hE, mk(0, 0, 0, 0, 0, sec, cur_opr, cur_opa));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("phase", 4'(phase), 4'(mon_e.ph));
      chk("sync", 4'(sync), 4'(mon_e.sy));
      chk("pcInc", 4'(pcInc), 4'(mon_e.pci));
      chk("tempWe", 4'(tempWe), 4'(mon_e.twe));
      chk("accWe", 4'(accWe), 4'(mon_e.awe));
      chk("secondCycle", 4'(secondCycle), 4'(mon_e.sec));
      chk("opr", opr, mon_e.opr);
      chk("opa", opa, mon_e.opa);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t, required < 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; runEn = 1'b1; dataIn = 4'h0;
`ifdef SEQ_SINGLE_STEP_EN
    stepReq = 1'b0;
`endif
    rst_clk();
    // run into X1 with SUB latched, then reset mid-cycle: accWe must never appear
    for (int p = 1; p <= 5; p++)
      drive(1'b0, 1'b1, (p == 4) ? 4'h9 : (p == 5) ? 4'h6 : 4'h0,
            mk(p, 0, p == 4, p == 5, 0, 0, (p >= 4) ? 4'h9 : 4'h0, (p >= 5) ? 4'h6 : 4'h0));
    repeat (3) rst_clk();
    push_cycle(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);  // NOP straight after reset
    push_cycle(0, 4'hD, 4'h5, 0, 0, 1, 4'hD, 4'h5);  // LDM 5
    push_cycle(0, 4'h8, 4'h3, 0, 1, 1, 4'h8, 4'h3);  // ADD R3
    push_cycle(0, 4'h4, 4'h2, 0, 0, 0, 4'h4, 4'h2);  // JUN
    push_cycle(0, 4'hA, 4'hB, 1, 0, 0, 4'h4, 4'h2);  // JUN word 2
    push_cycle(0, 4'h2, 4'h0, 0, 0, 0, 4'h2, 4'h0);  // FIM
    push_cycle(0, 4'h8, 4'h3, 1, 0, 0, 4'h2, 4'h0);  // FIM word 2 looks like ADD
    push_cycle(0, 4'h3, 4'h0, 0, 0, 0, 4'h3, 4'h0);  // FIN
    push_cycle(0, 4'hD, 4'h1, 1, 0, 0, 4'h3, 4'h0);  // FIN word 2 looks like LDM
    push_cycle(0, 4'h2, 4'h1, 0, 0, 0, 4'h2, 4'h1);  // SRC is one-word
    push_cycle(0, 4'hE, 4'h8, 0, 1, 1, 4'hE, 4'h8);  // SBM
    push_cycle(0, 4'hE, 4'h4, 0, 0, 0, 4'hE, 4'h4);  // WR0
    push_cycle(0, 4'hF, 4'h1, 0, 0, 0, 4'hF, 4'h1);  // CLC
    push_cycle(0, 4'hF, 4'h2, 0, 0, 1, 4'hF, 4'h2);  // IAC
    push_cycle(0, 4'hF, 4'hA, 0, 0, 0, 4'hF, 4'hA);  // STC
    push_cycle(0, 4'hC, 4'h0, 0, 0, 1, 4'hC, 4'h0);  // BBL
    stall(10, 0);
    push_cycle(1, 4'h9, 4'h4, 0, 1, 1, 4'h9, 4'h4);  // SUB after resume at A2
    push_cycle(0, 4'h5, 4'h0, 0, 0, 0, 4'h5, 4'h0);  // JMS
    stall(3, 1);
    push_cycle(1, 4'h8, 4'h8, 1, 0, 0, 4'h5, 4'h0);  // JMS word 2 after stall
    push_cycle(0, 4'h6, 4'h3, 0, 0, 0, 4'h6, 4'h3);  // INC
`ifdef SEQ_SINGLE_STEP_EN
    stall(3, 0);
    step_mode = 1'b1;
    push_cycle(1, 4'hF, 4'h1, 0, 0, 0, 4'hF, 4'h1);  // stepped CLC
    stall(4, 0);
    push_cycle(1, 4'hF, 4'h2, 0, 0, 1, 4'hF, 4'h2);  // stepped IAC
    stall(2, 0);
    step_mode = 1'b0;
    push_cycle(1, 4'hB, 4'h2, 0, 1, 1, 4'hB, 4'h2);  // XCH with runEn
`endif
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
